// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
// Holds the read-mode enum, the count-width function and the wrapping pointer increment.
package fifo_pkg;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } read_mode_e;

    // Count must represent 0..DEPTH inclusive, so it needs one more code than the pointers.
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap at depth-1 so non-power-of-two depths work.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo: handshake, data, fill count and status flags.
interface sync_fifo_if import fifo_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = cw_of(DEPTH);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, din, clr_err,
        input  dout, count, full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  push, pop, din, clr_err,
        output dout, count, full, empty, almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with any depth, standard or first-word-fall-through read,
// fill count, programmable almost thresholds and sticky overflow/underflow flags.
module sync_fifo #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus
);
    localparam int CW = fifo_pkg::cw_of(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam fifo_pkg::read_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic [WIDTH-1:0] rd_data;
    logic             full, empty, wr, rd;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign wr = bus.push & (~full | bus.pop);
    assign rd = bus.pop & ~empty;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr),
        .waddr (wr_ptr_reg),
        .wdata (bus.din),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        dout_next      = dout_reg;
        overflow_next  = overflow_reg & ~bus.clr_err;
        underflow_next = underflow_reg & ~bus.clr_err;

        if (wr) begin
            wr_ptr_next = PW'(fifo_pkg::ptr_inc(int'(wr_ptr_reg), DEPTH));
        end
        if (rd) begin
            rd_ptr_next = PW'(fifo_pkg::ptr_inc(int'(rd_ptr_reg), DEPTH));
            dout_next   = rd_data;
        end

        unique case ({wr, rd})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase

        // A new error in the clearing cycle takes priority over clr_err.
        if (bus.push & full & ~bus.pop) begin
            overflow_next = 1'b1;
        end
        if (bus.pop & empty) begin
            underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            dout_reg      <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            dout_reg      <= dout_next;
        end
    end

    assign bus.dout         = (MODE == fifo_pkg::FWFT) ? rd_data : dout_reg;
    assign bus.count        = count_reg;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (int'(count_reg) >= AF_LEVEL);
    assign bus.almost_empty = (int'(count_reg) <= AE_LEVEL);
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a standard-mode DEPTH=4 FIFO and an FWFT DEPTH=5 FIFO with identical stimulus
// and compares both against a shift-array queue model of the FIFO rules.
module tb_sync_fifo;

    logic clk;
    logic rst;

    sync_fifo_if #(.WIDTH(4), .DEPTH(4)) ifa ();
    sync_fifo_if #(.WIDTH(4), .DEPTH(5)) ifb ();

    sync_fifo #(
        .WIDTH(4), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    sync_fifo #(
        .WIDTH(4), .DEPTH(5), .FWFT(1), .AE_LEVEL(1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_cycle  = 0;

    // Model state per instance: index 0 = standard DEPTH 4, index 1 = FWFT DEPTH 5.
    int          depth_m [2];
    int          af_m    [2];
    int          fill_m  [2];
    logic [3:0]  q_m     [2][8];
    logic        ovf_m   [2];
    logic        unf_m   [2];
    logic [3:0]  dout_m  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n_cycle);
        end
    endtask

    task automatic model(input int i, input logic p, input logic q, input logic [3:0] d,
                         input logic c, input logic r);
        bit full_v;
        bit empty_v;
        bit wr_v;
        bit rd_v;
        full_v  = (fill_m[i] == depth_m[i]);
        empty_v = (fill_m[i] == 0);
        wr_v    = p && (!full_v || q);
        rd_v    = q && !empty_v;
        if (r) begin
            fill_m[i] = 0;
            ovf_m[i]  = 1'b0;
            unf_m[i]  = 1'b0;
            dout_m[i] = 4'h0;
        end else begin
            if (rd_v) begin
                dout_m[i] = q_m[i][0];
                for (int k = 0; k < 7; k++) q_m[i][k] = q_m[i][k+1];
                fill_m[i]--;
            end
            if (wr_v) begin
                q_m[i][fill_m[i]] = d;
                fill_m[i]++;
            end
            if (c) begin
                ovf_m[i] = 1'b0;
                unf_m[i] = 1'b0;
            end
            if (p && full_v && !q) ovf_m[i] = 1'b1;
            if (q && empty_v)      unf_m[i] = 1'b1;
        end
    endtask

    task automatic check_all(input int i, input string nm, input logic [3:0] dout, input int count,
                             input logic full, input logic empty, input logic af, input logic ae,
                             input logic ovf, input logic unf);
        check({nm, "_count"},     count, fill_m[i]);
        check({nm, "_full"},      full,  fill_m[i] == depth_m[i]);
        check({nm, "_empty"},     empty, fill_m[i] == 0);
        check({nm, "_afull"},     af,    fill_m[i] >= af_m[i]);
        check({nm, "_aempty"},    ae,    fill_m[i] <= 1);
        check({nm, "_overflow"},  ovf,   ovf_m[i]);
        check({nm, "_underflow"}, unf,   unf_m[i]);
        if (i == 0) begin
            check({nm, "_dout"}, dout, dout_m[i]);
        end else if (fill_m[i] > 0) begin
            check({nm, "_dout"}, dout, q_m[i][0]);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [3:0] d,
                        input logic c, input logic r);
        ifa.push = p; ifa.pop = q; ifa.din = d; ifa.clr_err = c;
        ifb.push = p; ifb.pop = q; ifb.din = d; ifb.clr_err = c;
        rst = r;
        @(posedge clk);
        model(0, p, q, d, c, r);
        model(1, p, q, d, c, r);
        #1;
        n_cycle++;
        $display("cyc %0d rst=%b push=%b pop=%b din=%h clr=%b | a cnt=%0d dout=%h | b cnt=%0d dout=%h",
                 n_cycle, r, p, q, d, c, ifa.count, ifa.dout, ifb.count, ifb.dout);
        check_all(0, "a", ifa.dout, int'(ifa.count), ifa.full, ifa.empty, ifa.almost_full,
                  ifa.almost_empty, ifa.overflow, ifa.underflow);
        check_all(1, "b", ifb.dout, int'(ifb.count), ifb.full, ifb.empty, ifb.almost_full,
                  ifb.almost_empty, ifb.overflow, ifb.underflow);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        depth_m = '{4, 5};
        af_m    = '{3, 4};
        fill_m  = '{0, 0};
        ovf_m   = '{1'b0, 1'b0};
        unf_m   = '{1'b0, 1'b0};
        dout_m  = '{4'h0, 4'h0};
        ifa.push = 1'b0; ifa.pop = 1'b0; ifa.din = '0; ifa.clr_err = 1'b0;
        ifb.push = 1'b0; ifb.pop = 1'b0; ifb.din = '0; ifb.clr_err = 1'b0;

        // Reset, then fill 0..3 and try to overflow.
        step(0, 0, 4'h0, 0, 1);
        step(0, 0, 4'h0, 0, 1);
        for (int v = 0; v < 4; v++) step(1, 0, 4'(v), 0, 0);
        step(1, 0, 4'h5, 0, 0);
        step(1, 0, 4'h6, 0, 0);
        step(0, 0, 4'h0, 1, 0);
        // Push and pop together while full, then drain past empty.
        step(1, 1, 4'h9, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 4'h0, 0, 0);
        step(0, 0, 4'h0, 1, 0);
        // Push and pop together while empty: push lands, pop refused.
        step(1, 1, 4'h7, 0, 0);
        step(0, 1, 4'h0, 0, 0);
        step(0, 0, 4'h0, 1, 0);
        // Occupancy held at 2 across pointer wrap.
        step(1, 0, 4'h0, 0, 0);
        step(1, 0, 4'h1, 0, 0);
        for (int v = 2; v < 14; v++) step(1, 1, 4'(v), 0, 0);
        step(0, 1, 4'h0, 0, 0);
        step(0, 1, 4'h0, 0, 0);
        // Mid-operation reset with a push pending, then pop from empty.
        for (int v = 0; v < 3; v++) step(1, 0, 4'(v + 10), 0, 0);
        step(1, 0, 4'hE, 0, 1);
        step(0, 1, 4'h0, 0, 0);
        step(0, 0, 4'h0, 0, 0);

        // Random traffic with phases biased toward filling and draining.
        for (int n = 0; n < 600; n++) begin
            int unsigned pp;
            int unsigned qp;
            pp = ((n / 50) % 2 == 0) ? 70 : 30;
            qp = 100 - pp;
            step($urandom_range(99) < pp, $urandom_range(99) < qp, 4'($urandom),
                 $urandom_range(15) == 0, $urandom_range(149) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
